// File: rtl/clk_buf_monitor.sv
// clk_buf_monitor: measures the frequency of a buffered clock.
// The monitored clock is synchronised into the clk domain. Its rising edges
// are counted over windows of WINDOW reference cycles, and each window is
// range-checked against EXP_MIN..EXP_MAX.
//
// Optional feature: define CLK_BUF_MONITOR_STUCK_DETECT_EN to build the
// stuck-clock detector. Without it, clock_stuck is tied to 0.
//
// Output protocol: count_valid is a one-cycle pulse with no back-pressure.
// edge_count, freq_ok and mismatch_count change only in that cycle and hold
// their values otherwise, including while the monitor is idle.
module clk_buf_monitor #(
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned EXP_MIN     = 15,
  parameter int unsigned EXP_MAX     = 17,
  parameter int unsigned STUCK_LIMIT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clock_input,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid,
  output logic             freq_ok,
  output logic [7:0]       mismatch_count,
  output logic             clock_stuck
);

  localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t           state;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             s1, s2, s3;
  logic             rise;
  logic             in_range;
  logic [CNT_W-1:0] edge_cnt_inc;

  // Two-flop synchroniser plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clock_input;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // The edge counter saturates instead of wrapping. The range check uses the count so far.
  assign edge_cnt_inc = (edge_cnt == {CNT_W{1'b1}}) ? edge_cnt : edge_cnt + 1'b1;
  assign in_range     = (edge_cnt >= CNT_W'(EXP_MIN)) && (edge_cnt <= CNT_W'(EXP_MAX));

  // Window FSM: idle, then count for WINDOW cycles, then one report cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      win_cnt        <= '0;
      edge_cnt       <= '0;
      edge_count     <= '0;
      count_valid    <= 1'b0;
      freq_ok        <= 1'b0;
      mismatch_count <= 8'd0;
    end else begin
      count_valid <= 1'b0;
      case (state)
        IDLE: begin
          win_cnt  <= '0;
          edge_cnt <= '0;
          if (enable) state <= MEASURE;
        end
        MEASURE: begin
          if (!enable) begin
            // An aborted window is dropped without a report.
            state    <= IDLE;
            win_cnt  <= '0;
            edge_cnt <= '0;
          end else begin
            if (rise) edge_cnt <= edge_cnt_inc;
            if (win_cnt == WIN_LAST) begin
              state   <= REPORT;
              win_cnt <= '0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
            end
          end
        end
        REPORT: begin
          edge_count  <= edge_cnt;
          count_valid <= 1'b1;
          freq_ok     <= in_range;
          if (!in_range && (mismatch_count != 8'hFF))
            mismatch_count <= mismatch_count + 8'd1;
          // A rise during the report cycle becomes the first edge of the next window.
          edge_cnt <= rise ? CNT_W'(1) : '0;
          win_cnt  <= '0;
          state    <= enable ? MEASURE : IDLE;
        end
        default: begin
          state    <= IDLE;
          win_cnt  <= '0;
          edge_cnt <= '0;
        end
      endcase
    end
  end

`ifdef CLK_BUF_MONITOR_STUCK_DETECT_EN
  localparam int unsigned ST_W = $clog2(STUCK_LIMIT + 1);

  logic [ST_W-1:0] stuck_cnt;

  // Cycles since the last synchronised edge, which saturates at STUCK_LIMIT. This counter runs in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      stuck_cnt   <= '0;
      clock_stuck <= 1'b0;
    end else if (rise) begin
      stuck_cnt   <= '0;
      clock_stuck <= 1'b0;
    end else begin
      if (stuck_cnt != ST_W'(STUCK_LIMIT)) stuck_cnt <= stuck_cnt + 1'b1;
      if (stuck_cnt >= ST_W'(STUCK_LIMIT - 1)) clock_stuck <= 1'b1;
    end
  end
`else
  assign clock_stuck = 1'b0;
`endif

endmodule
